// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of the two requester channels, the shared-ALU hookup
//               and the registered response channel of alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    // Requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_ctrl;
    // Requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_ctrl;
    // Shared combinational ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    // Response
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready
    );

    // Requester / consumer / ALU side
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of a shared combinational ALU.
//               The granted request's operands are steered to the ALU and the
//               result is captured in a single-entry response register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input wire logic     clk,
    input wire logic     rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [3:0] c_IDLE_CTRL = 4'b1111;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;

    logic        w_can_accept;
    logic        w_grant_valid;
    logic        w_grant_id;

    // Arbitration: decide whether a grant happens this cycle and to whom.
    // Reset is folded in so no ready leaks out while rst is held.
    always_comb begin
        w_can_accept  = !rst && ((state_q == EMPTY) || bus.rsp_ready);
        w_grant_valid = w_can_accept && (bus.req0_valid || bus.req1_valid);
        w_grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = RR_EN ? prio_q : 1'b0;
        end else if (bus.req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // Handshake outputs and operand steering toward the shared ALU.
    always_comb begin
        bus.req0_ready  = w_grant_valid && !w_grant_id;
        bus.req1_ready  = w_grant_valid &&  w_grant_id;
        bus.alu_a       = 32'd0;
        bus.alu_b       = 32'd0;
        bus.alu_control = c_IDLE_CTRL;
        if (w_grant_valid) begin
            if (w_grant_id) begin
                bus.alu_a       = bus.req1_a;
                bus.alu_b       = bus.req1_b;
                bus.alu_control = bus.req1_ctrl;
            end else begin
                bus.alu_a       = bus.req0_a;
                bus.alu_b       = bus.req0_b;
                bus.alu_control = bus.req0_ctrl;
            end
        end
    end

    // Next-state: a grant always (re)fills the response register, which also
    // covers drain-and-refill; an unrefilled drain empties it.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (w_grant_valid) begin
            state_d      = FULL;
            rsp_id_d     = w_grant_id;
            rsp_result_d = bus.alu_result;
            if (RR_EN) begin
                prio_d = ~w_grant_id;
            end
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // State and response registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            prio_q       <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    // Response channel is a direct view of the registers.
    always_comb begin
        bus.rsp_valid  = (state_q == FULL);
        bus.rsp_id     = rsp_id_q;
        bus.rsp_result = rsp_result_q;
    end

endmodule
`default_nettype wire
